// File: rtl/mux_data_gen_pkg.sv
// Shared types and helpers for the mux_data_gen byte-stream router.
// Destination encoding, port count and destination-index helpers.
package mux_data_gen_pkg;

    localparam int SEL_W   = 3;
    localparam int NUM_DST = 5;

    typedef enum logic [SEL_W-1:0] {
        DST_M1 = 3'd0,
        DST_M2 = 3'd1,
        DST_S1 = 3'd2,
        DST_S2 = 3'd3,
        DST_S3 = 3'd4
    } dst_e;

    function automatic logic dst_valid(input logic [SEL_W-1:0] sel);
        return (sel <= 3'(DST_S3));
    endfunction

    // Ready of the downstream port addressed by idx; invalid indices read as not ready.
    function automatic logic pick_ready(input logic [NUM_DST-1:0] vec,
                                        input logic [SEL_W-1:0]   idx);
        logic r;
        case (idx)
            3'd0:    r = vec[0];
            3'd1:    r = vec[1];
            3'd2:    r = vec[2];
            3'd3:    r = vec[3];
            3'd4:    r = vec[4];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mux_data_gen_reg_slice.sv
// One-deep AXI-Stream register (payload tdata, tlast, destination index).
// Only built when MUX_DATA_GEN_REG_OUT_EN is defined.
`ifdef MUX_DATA_GEN_REG_OUT_EN
module axis_reg_slice
    import mux_data_gen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DST_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [DST_W-1:0]  in_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [DST_W-1:0]  out_dst
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [DST_W-1:0]  dst_q, dst_d;
    logic              load_s;

    // A drain and a reload on the same edge keep the slice full with no bubble.
    always_comb begin
        in_ready = !valid_q || out_ready;
        load_s   = in_valid && in_ready;
        data_d   = data_q;
        last_d   = last_q;
        dst_d    = dst_q;
        if (load_s) begin
            valid_d = 1'b1;
            data_d  = in_data;
            last_d  = in_last;
            dst_d   = in_dst;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slice state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            dst_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            dst_q   <= dst_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_dst   = dst_q;

endmodule
`endif

// File: rtl/mux_data_gen.sv
// Routes one byte AXI-Stream to one of five ports, destination locked per packet.
// Define MUX_DATA_GEN_REG_OUT_EN to add a one-deep output register slice.
module mux_data_gen
    import mux_data_gen_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DATA_W-1:0]     tdata,
    input  logic                  tvalid,
    input  logic                  tlast,
    output logic                  tready,
    output logic [DATA_W-1:0]     tdata_m1,
    output logic [DATA_W-1:0]     tdata_m2,
    output logic [DATA_W-1:0]     tdata_s1,
    output logic [DATA_W-1:0]     tdata_s2,
    output logic [DATA_W-1:0]     tdata_s3,
    output logic                  tvalid_m1,
    output logic                  tvalid_m2,
    output logic                  tvalid_s1,
    output logic                  tvalid_s2,
    output logic                  tvalid_s3,
    output logic                  tlast_m1,
    output logic                  tlast_m2,
    output logic                  tlast_s1,
    output logic                  tlast_s2,
    output logic                  tlast_s3,
    input  logic                  tready_m1,
    input  logic                  tready_m2,
    input  logic                  tready_s1,
    input  logic                  tready_s2,
    input  logic                  tready_s3,
    output logic                  pkt_active,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  pkt_active_q, pkt_active_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [SEL_W-1:0]   dst_s;
    logic               dst_ok_s;
    logic               fwd_valid_s;
    logic               fwd_ready_s;
    logic               accept_s;
    logic [NUM_DST-1:0] ds_ready_s;
    logic               out_valid_s;
    logic [DATA_W-1:0]  out_data_s;
    logic               out_last_s;
    logic [SEL_W-1:0]   out_dst_s;
    logic [NUM_DST-1:0] port_valid_s;
    logic [NUM_DST-1:0] port_last_s;
    logic [DATA_W-1:0]  port_data_s [NUM_DST];

    assign ds_ready_s = {tready_s3, tready_s2, tready_s1, tready_m2, tready_m1};

    // Destination is frozen for the rest of a packet once its first beat is taken.
    always_comb begin
        dst_s       = pkt_active_q ? sel_q : sel;
        dst_ok_s    = dst_valid(dst_s);
        fwd_valid_s = tvalid && dst_ok_s && !rst;
    end

`ifdef MUX_DATA_GEN_REG_OUT_EN
    logic drain_ready_s;

    assign drain_ready_s = pick_ready(ds_ready_s, out_dst_s);

    axis_reg_slice #(
        .DATA_W (DATA_W),
        .DST_W  (SEL_W)
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fwd_valid_s),
        .in_ready  (fwd_ready_s),
        .in_data   (tdata),
        .in_last   (tlast),
        .in_dst    (dst_s),
        .out_valid (out_valid_s),
        .out_ready (drain_ready_s),
        .out_data  (out_data_s),
        .out_last  (out_last_s),
        .out_dst   (out_dst_s)
    );
`else
    assign fwd_ready_s = pick_ready(ds_ready_s, dst_s);
    assign out_valid_s = fwd_valid_s;
    assign out_data_s  = tdata;
    assign out_last_s  = tlast;
    assign out_dst_s   = dst_s;
`endif

    // Invalid destinations are sunk immediately so they never stall the source.
    always_comb begin
        if (rst) begin
            tready = 1'b0;
        end else if (dst_ok_s) begin
            tready = fwd_ready_s;
        end else begin
            tready = 1'b1;
        end
        accept_s = tvalid && tready;
    end

    // Fan the single output beat out to its port; every other port reads zero.
    always_comb begin
        port_valid_s = '0;
        port_last_s  = '0;
        for (int i = 0; i < NUM_DST; i++) begin
            port_data_s[i] = '0;
            if (out_valid_s && (out_dst_s == 3'(i))) begin
                port_valid_s[i] = 1'b1;
                port_last_s[i]  = out_last_s;
                port_data_s[i]  = out_data_s;
            end else begin
                port_valid_s[i] = 1'b0;
            end
        end
    end

    // Packet lock and saturating drop counter update.
    always_comb begin
        sel_d        = sel_q;
        pkt_active_d = pkt_active_q;
        drop_cnt_d   = drop_cnt_q;
        if (accept_s) begin
            pkt_active_d = !tlast;
            if (!pkt_active_q) begin
                sel_d = sel;
            end else begin
                sel_d = sel_q;
            end
            if (!dst_ok_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
                drop_cnt_d = drop_cnt_q + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            pkt_active_d = pkt_active_q;
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q        <= '0;
            pkt_active_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            sel_q        <= sel_d;
            pkt_active_q <= pkt_active_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign pkt_active = pkt_active_q;
    assign drop_cnt   = drop_cnt_q;

    assign {tvalid_s3, tvalid_s2, tvalid_s1, tvalid_m2, tvalid_m1} = port_valid_s;
    assign {tlast_s3, tlast_s2, tlast_s1, tlast_m2, tlast_m1}      = port_last_s;
    assign tdata_m1 = port_data_s[0];
    assign tdata_m2 = port_data_s[1];
    assign tdata_s1 = port_data_s[2];
    assign tdata_s2 = port_data_s[3];
    assign tdata_s3 = port_data_s[4];

endmodule

// File: tb/tb_mux_data_gen.sv
// Self-checking bench for mux_data_gen: per-port scoreboard plus scenario tasks.
// Works for both builds (MUX_DATA_GEN_REG_OUT_EN defined or not).
module tb_mux_data_gen;
    import mux_data_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sel = 3'd0;
    logic [7:0] tdata = 8'd0;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic [4:0] rdy = 5'b11111;
    wire        tready;
    wire [7:0]  tdata_m1, tdata_m2, tdata_s1, tdata_s2, tdata_s3;
    wire        tvalid_m1, tvalid_m2, tvalid_s1, tvalid_s2, tvalid_s3;
    wire        tlast_m1, tlast_m2, tlast_s1, tlast_s2, tlast_s3;
    wire        pkt_active;
    wire [7:0]  drop_cnt;

    logic [4:0] vo, lo;
    logic [7:0] dout [5];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: lock state, drop count and expected beats per port.
    logic       m_active = 1'b0;
    logic [2:0] m_selq = 3'd0;
    int         m_drop = 0;
    logic [2:0] m_d;
    logic       m_rdy;
    logic [8:0] m_exp;
    logic [8:0] sb [5][$];

    mux_data_gen dut (
        .clk(clk), .rst(rst), .sel(sel), .tdata(tdata), .tvalid(tvalid), .tlast(tlast),
        .tready(tready),
        .tdata_m1(tdata_m1), .tdata_m2(tdata_m2), .tdata_s1(tdata_s1),
        .tdata_s2(tdata_s2), .tdata_s3(tdata_s3),
        .tvalid_m1(tvalid_m1), .tvalid_m2(tvalid_m2), .tvalid_s1(tvalid_s1),
        .tvalid_s2(tvalid_s2), .tvalid_s3(tvalid_s3),
        .tlast_m1(tlast_m1), .tlast_m2(tlast_m2), .tlast_s1(tlast_s1),
        .tlast_s2(tlast_s2), .tlast_s3(tlast_s3),
        .tready_m1(rdy[0]), .tready_m2(rdy[1]), .tready_s1(rdy[2]),
        .tready_s2(rdy[3]), .tready_s3(rdy[4]),
        .pkt_active(pkt_active), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    assign vo = {tvalid_s3, tvalid_s2, tvalid_s1, tvalid_m2, tvalid_m1};
    assign lo = {tlast_s3, tlast_s2, tlast_s1, tlast_m2, tlast_m1};
    always_comb begin
        dout[0] = tdata_m1;
        dout[1] = tdata_m2;
        dout[2] = tdata_s1;
        dout[3] = tdata_s2;
        dout[4] = tdata_s3;
    end

    // Monitor: compare DUT against the model every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_selq   = 3'd0;
            m_drop   = 0;
            for (int i = 0; i < 5; i++) sb[i].delete();
            vectors++;
            if (vo !== 5'd0 || lo !== 5'd0 || tready !== 1'b0 || pkt_active !== 1'b0 ||
                drop_cnt !== 8'd0 || (dout[0] | dout[1] | dout[2] | dout[3] | dout[4]) !== 8'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: vo=%b lo=%b tready=%b pkt=%b drop=%0d, required all zero",
                         vo, lo, tready, pkt_active, drop_cnt);
            end
        end else begin
            m_d = m_active ? m_selq : sel;
            vectors++;
            if (pkt_active !== m_active) begin
                miscompares++;
                $display("FAIL pkt_active: got %b, required %b", pkt_active, m_active);
            end
            vectors++;
            if (drop_cnt !== m_drop[7:0]) begin
                miscompares++;
                $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, m_drop);
            end
            m_rdy = (m_d < 3'd5) ? rdy[m_d] : 1'b1;
`ifndef MUX_DATA_GEN_REG_OUT_EN
            vectors++;
            if (tready !== m_rdy) begin
                miscompares++;
                $display("FAIL tready_direct: got %b, required %b (dst %0d)", tready, m_rdy, m_d);
            end
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (vo[i] !== (tvalid && (m_d == 3'(i)))) begin
                    miscompares++;
                    $display("FAIL tvalid_port%0d: got %b, required %b", i, vo[i], tvalid && (m_d == 3'(i)));
                end
            end
`else
            if (m_d >= 3'd5) begin
                vectors++;
                if (tready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL tready_invalid_sel: got %b, required 1", tready);
                end
            end
            vectors++;
            if ($countones(vo) > 1) begin
                miscompares++;
                $display("FAIL one_hot_valid: got %b, required at most one bit", vo);
            end
`endif
            for (int i = 0; i < 5; i++) begin
                if (!vo[i]) begin
                    vectors++;
                    if (dout[i] !== 8'd0 || lo[i] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL idle_port%0d: data=%h last=%b, required 0/0", i, dout[i], lo[i]);
                    end
                end
            end
            if (tvalid && tready) begin
                if (m_d < 3'd5) sb[m_d].push_back({tlast, tdata});
                else if (m_drop < 255) m_drop++;
                if (!m_active) m_selq = sel;
                m_active = !tlast;
            end
            for (int i = 0; i < 5; i++) begin
                if (vo[i] && rdy[i]) begin
                    vectors++;
                    if (sb[i].size() == 0) begin
                        miscompares++;
                        $display("FAIL beat_port%0d: got unexpected %h/%b, required no beat", i, dout[i], lo[i]);
                    end else begin
                        m_exp = sb[i].pop_front();
                        if ({lo[i], dout[i]} !== m_exp) begin
                            miscompares++;
                            $display("FAIL beat_port%0d: got %b/%h, required %b/%h",
                                     i, lo[i], dout[i], m_exp[8], m_exp[7:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        tvalid = 1'b0;
        rdy = 5'b11111;
        while (n < 10 && (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() + sb[4].size()) != 0) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() + sb[4].size()) != 0) begin
            miscompares++;
            $display("FAIL drain: %0d beats still pending, required 0",
                     sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() + sb[4].size());
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        bit done = 1'b0;
        tdata = d; tlast = l; tvalid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (tready) done = 1'b1;
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL send_timeout: beat %h not accepted in 50 cycles", d);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (tready !== 1'b0 || vo !== 5'd0 || pkt_active !== 1'b0 || drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL test_reset: tready=%b vo=%b pkt=%b drop=%0d, required 0", tready, vo, pkt_active, drop_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        bit seen = 1'b0;
        rdy = 5'b11111; sel = 3'd2; tdata = 8'hA5; tlast = 1'b1; tvalid = 1'b1;
        for (int n = 0; n < 4 && !seen; n++) begin
            @(negedge clk);
            if (tvalid_s1) begin
                seen = 1'b1;
                vectors++;
                if (tdata_s1 !== 8'hA5 || tlast_s1 !== 1'b1 || vo !== 5'b00100) begin
                    miscompares++;
                    $display("FAIL single_beat: data=%h last=%b vo=%b, required a5/1/00100", tdata_s1, tlast_s1, vo);
                end
            end
            @(posedge clk); #1;
            tvalid = 1'b0;
        end
        vectors++;
        if (!seen || pkt_active !== 1'b0) begin
            miscompares++;
            $display("FAIL single_beat_seen: seen=%b pkt=%b, required 1/0", seen, pkt_active);
        end
        drain();
    endtask

    task automatic test_locked_packet();
        rdy = 5'b11111; sel = 3'd0;
        for (int k = 1; k <= 4; k++) begin
            send_beat(8'(k), k == 4);
            if (k == 1) sel = 3'd3;
            @(negedge clk);
            vectors++;
            if (pkt_active !== (k < 4)) begin
                miscompares++;
                $display("FAIL locked_pkt_active: after beat %0d got %b, required %b", k, pkt_active, k < 4);
            end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_stall();
        bit held_seen = 1'b0;
        logic [7:0] held = 8'd0;
        sel = 3'd4; rdy[4] = 1'b0; tdata = 8'($urandom); tlast = 1'b0; tvalid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
`ifndef MUX_DATA_GEN_REG_OUT_EN
            vectors++;
            if (tready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_tready: got %b, required 0", tready);
            end
`else
            if (tvalid_s3) begin
                if (!held_seen) begin
                    held = tdata_s3; held_seen = 1'b1;
                end else begin
                    vectors++;
                    if (tdata_s3 !== held) begin
                        miscompares++;
                        $display("FAIL stall_stable: got %h, required %h", tdata_s3, held);
                    end
                end
            end
`endif
            if (tready) begin
                @(posedge clk); #1;
                tdata = 8'($urandom);
            end else begin
                @(posedge clk); #1;
            end
        end
`ifdef MUX_DATA_GEN_REG_OUT_EN
        vectors++;
        if (!held_seen) begin
            miscompares++;
            $display("FAIL stall_held: no held beat on s3, required one");
        end
`endif
        rdy[4] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) send_beat(8'($urandom), k == 2);
        drain();
    endtask

    task automatic test_drop();
        sel = 3'd6; tvalid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            tdata = 8'($urandom); tlast = 1'($urandom);
            @(negedge clk);
            vectors++;
            if (tready !== 1'b1 || vo !== 5'd0) begin
                miscompares++;
                $display("FAIL drop_beat: tready=%b vo=%b, required 1/00000", tready, vo);
            end
            @(posedge clk); #1;
        end
        tvalid = 1'b0; tlast = 1'b0;
        @(negedge clk);
        vectors++;
        if (drop_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL drop_saturate: got %0d, required 255", drop_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        sel = 3'd1; rdy[1] = 1'b0; tdata = 8'h3C; tlast = 1'b0; tvalid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1; tvalid = 1'b0;
        @(negedge clk);
        vectors++;
        if (vo !== 5'd0 || pkt_active !== 1'b0 || tready !== 1'b0 || drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid: vo=%b pkt=%b tready=%b drop=%0d, required 0", vo, pkt_active, tready, drop_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0; rdy = 5'b11111;
        sel = 3'd3; tdata = 8'h77; tlast = 1'b1; tvalid = 1'b1;
        for (int n = 0; n < 4 && !seen; n++) begin
            @(negedge clk);
            if (tvalid_s2) begin
                seen = 1'b1;
                vectors++;
                if (tdata_s2 !== 8'h77 || vo !== 5'b01000) begin
                    miscompares++;
                    $display("FAIL reset_mid_route: data=%h vo=%b, required 77/01000", tdata_s2, vo);
                end
            end
            @(posedge clk); #1;
            tvalid = 1'b0;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL reset_mid_seen: got no beat on s2, required one");
        end
        drain();
    endtask

`ifdef MUX_DATA_GEN_REG_OUT_EN
    task automatic test_throughput();
        rdy = 5'b11111; sel = 3'd1;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                tvalid = 1'b1; tdata = 8'h10 + 8'(k); tlast = (k == 7);
            end else begin
                tvalid = 1'b0; tlast = 1'b0;
            end
            @(negedge clk);
            if (k < 8) begin
                vectors++;
                if (tready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL thru_tready: cycle %0d got %b, required 1", k, tready);
                end
            end
            vectors++;
            if (k == 0 && tvalid_m2 !== 1'b0) begin
                miscompares++;
                $display("FAIL thru_latency: m2 valid before first edge, required 0");
            end else if (k > 0 && (tvalid_m2 !== 1'b1 || tdata_m2 !== 8'h10 + 8'(k - 1))) begin
                miscompares++;
                $display("FAIL thru_beat: cycle %0d got %b/%h, required 1/%h", k, tvalid_m2, tdata_m2, 8'h10 + 8'(k - 1));
            end
            @(posedge clk); #1;
        end
        drain();
    endtask
`endif

    task automatic test_random();
        bit hold = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!hold) begin
                tvalid = ($urandom_range(3) != 0);
                tdata  = 8'($urandom);
                tlast  = ($urandom_range(2) == 0);
                if ($urandom_range(3) == 0) sel = 3'($urandom_range(7));
            end
            for (int i = 0; i < 5; i++) rdy[i] = ($urandom_range(3) != 0);
            @(negedge clk);
            hold = tvalid && !tready;
            @(posedge clk); #1;
        end
        tlast = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_locked_packet();
        test_stall();
        test_drop();
`ifdef MUX_DATA_GEN_REG_OUT_EN
        test_throughput();
`endif
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_data_gen.md
# mux_data_gen

Byte-wide AXI-Stream router that steers one upstream stream (from the bench stream generator) to one of five downstream data ports: master 1, master 2, slave 1, slave 2, slave 3. It sits between the stream source and the `s_axis_data_*` inputs of the I2C controllers. The destination is locked per packet. Beats sent to an invalid destination are discarded and counted.

## Interface
- `DATA_W`, 8: tdata width of upstream and all downstream ports.
- `DROP_CNT_W`, 8: width of the saturating drop counter.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `sel`, in, 3: destination select. 0=m1, 1=m2, 2=s1, 3=s2, 4=s3; 5–7 are invalid.
- `tdata`, in, DATA_W: upstream data.
- `tvalid`, in, 1: upstream valid.
- `tlast`, in, 1: upstream end of packet.
- `tready`, out, 1: upstream ready.
- `tdata_m1` / `_m2` / `_s1` / `_s2` / `_s3`, out, DATA_W: downstream data.
- `tvalid_m1` … `tvalid_s3`, out, 1: downstream valid.
- `tlast_m1` … `tlast_s3`, out, 1: downstream last.
- `tready_m1` … `tready_s3`, in, 1: downstream ready.
- `pkt_active`, out, 1: a packet is in progress and the destination is locked.
- `drop_cnt`, out, DROP_CNT_W: number of beats discarded to an invalid `sel`. Saturates at all-ones.

## Operation
- Effective destination `dst`:
  - `pkt_active ? sel_q : sel`.
  - `sel_q` is captured on any accepted beat when `pkt_active=0`.
- `pkt_active`:
  - Sets on an accepted beat with `tlast=0`.
  - Clears on an accepted beat with `tlast=1`.
  - A single-beat packet never sets it.
- Changes to `sel` while `pkt_active=1` are ignored until the packet ends.
- A beat is accepted when `tvalid && tready`.
- Valid `dst`: the beat is forwarded to port `dst` only.
  - Every non-selected output has tvalid=0, tdata=0, tlast=0.
- Invalid `dst` (5–7):
  - `tready=1`.
  - The beat is discarded.
  - `drop_cnt` increments by 1 per accepted beat and saturates with no wrap.
  - Packet locking applies identically.
- Data, tlast and beat order are preserved exactly. No beat is duplicated or lost on a valid route.
- Reset mid-packet:
  - Any held beat is discarded.
  - `pkt_active=0`.
  - `drop_cnt=0`.
  - The next beat re-samples `sel`.

## Timing
- Reset values:
  - All `tvalid_*` = 0, `tlast_*` = 0, `tdata_*` = 0.
  - `tready=0` while `rst=1`.
  - `pkt_active=0`, `drop_cnt=0`.
- Direct path (macro absent):
  - Combinational, zero latency: `tready = tready_<dst>` and `tvalid_<dst> = tvalid`.
  - No dependency of tvalid on tready is introduced.
- Registered path (macro present):
  - A beat accepted at edge N is presented on port `dst` from cycle N+1.
  - `tready = !hold_valid || tready_<hold_dst>`, giving full throughput of 1 beat/cycle under continuous ready.
  - Held beat stalls while its downstream ready is low. Its outputs are stable; AXI rule: no retraction.
  - Simultaneous case: if the held beat drains and a new beat is accepted on the same edge, the register reloads with no bubble.
- Invalid-sel beats are always accepted in 1 cycle on both paths. They are never registered.

## Configuration
- `MUX_DATA_GEN_REG_OUT_EN`:
  - Defined: inserts a one-deep output register slice (payload plus destination index) between the router and the downstream ports, with 1-cycle latency as above.
  - Undefined: purely combinational forwarding. `sel_q`, `pkt_active` and `drop_cnt` stay registered in both builds.

## Structure
- Package `mux_data_gen_pkg` holds:
  - `dst_e` enum: `DST_M1=0`, `DST_M2`, `DST_S1`, `DST_S2`, `DST_S3=4`.
  - `NUM_DST=5`.
  - Function `dst_valid(sel)` (true for 0–4).
- Sub-module `axis_reg_slice`: one-deep AXI-Stream register with payload {tdata, tlast, dst}. It is instantiated only under `MUX_DATA_GEN_REG_OUT_EN`.

## Test plan
- sel=2, single beat 0xA5 with tlast=1, tready_s1=1 → `tdata_s1=0xA5`, `tlast_s1=1`; all other tvalid_*=0; `pkt_active` stays 0.
- sel=0, 4-beat packet 0x01..0x04; sel changed to 3 after beat 1 → all four beats on m1 in order; `pkt_active` is 1 from beat 1 to beat 3 and clears after beat 4.
- sel=4, tready_s3 held 0 for 5 cycles → `tready=0` (direct) or a single stalled beat with stable outputs (registered); on release, beats follow with no loss.
- sel=6, 300 beats → `tready=1` throughout; no downstream tvalid; `drop_cnt` saturates at 255.
- Continuous stream to m2 with tready_m2=1, registered build → 1 beat/cycle, first output 1 cycle after acceptance.
- Assert `rst` mid-packet → all outputs 0 and `pkt_active=0`; after release, the next beat routes per the new sel.
